// File: rtl/load_store_unit_pkg.sv
// Shared types and legality helpers for the memory stage.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_DONE
  } lsu_state_t;

  function automatic logic f3_illegal(
    input logic [2:0] f3,
    input logic       is_st
  );
    return (f3 == 3'd3) || (f3 >= 3'd6) ||
           (is_st && (f3 >= 3'd3));
  endfunction

  function automatic logic misalign(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    return (((f3 == 3'd1) || (f3 == 3'd5)) && lo[0]) ||
           ((f3 == 3'd2) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication, byte enables,
// and load lane select with sign/zero extension.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic [15:0] half;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    half    = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o = wdata_i;
    be_o    = 4'b1111;
    rdata_o = rdata_i;
    case (size_i)
      MEM_B, MEM_BU: begin
        wdata_o = {4{wdata_i[7:0]}};
        be_o    = 4'b0001 << off_i;
        rdata_o = (size_i == MEM_B) ?
                  {{24{shifted[7]}}, shifted[7:0]} :
                  {24'b0, shifted[7:0]};
      end
      MEM_H, MEM_HU: begin
        wdata_o = {2{wdata_i[15:0]}};
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        rdata_o = (size_i == MEM_H) ?
                  {{16{half[15]}}, half} :
                  {16'b0, half};
      end
      default: begin
        wdata_o = wdata_i;
        be_o    = 4'b1111;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: data-bus handshake, legality checks,
// timeout and single-cycle completion reporting.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_error,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_we,
  output logic        bus_re,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  lsu_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        st_q, st_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] baddr_q, baddr_d;
  logic [31:0] bwd_q, bwd_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;
  logic        err_q, err_d;

  logic        req, ill_in, mis_in, idle;
  logic [2:0]  sel_size;
  logic [1:0]  sel_off;
  logic [31:0] al_wdata, al_rdata;
  logic [3:0]  al_be;

  assign req    = re | we;
  assign idle   = (state_q == LSU_IDLE);
  assign ill_in = (re & we) | f3_illegal(funct3, we);
  assign mis_in = misalign(funct3, addr[1:0]);

  // Aligner sees live inputs while idle, captured access in REQ
  assign sel_size = idle ? funct3 : size_q;
  assign sel_off  = idle ? addr[1:0] : off_q;

  lsu_lane_align u_align (
    .size_i  (mem_size_t'(sel_size)),
    .off_i   (sel_off),
    .wdata_i (wdata),
    .rdata_i (bus_rdata),
    .wdata_o (al_wdata),
    .be_o    (al_be),
    .rdata_o (al_rdata)
  );

  assign bus_addr  = baddr_q;
  assign bus_wdata = bwd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      st_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      baddr_q <= '0;
      bwd_q   <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      size_q  <= size_d;
      off_q   <= off_d;
      baddr_q <= baddr_d;
      bwd_q   <= bwd_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    st_d       = st_q;
    size_d     = size_q;
    off_d      = off_q;
    baddr_d    = baddr_q;
    bwd_d      = bwd_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    ill_d      = ill_q;
    err_d      = err_q;
    stall      = 1'b0;
    done       = 1'b0;
    rdata      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    bus_error  = 1'b0;
    bus_be     = '0;
    bus_we     = 1'b0;
    bus_re     = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        stall = req;
        if (req) begin
          st_d    = we;
          size_d  = funct3;
          off_d   = addr[1:0];
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          ill_d   = ill_in;
          mis_d   = mis_in & ~ill_in;
          if (ill_in || mis_in) begin
            state_d = LSU_DONE;
          end else begin
            state_d = LSU_REQ;
            baddr_d = {addr[31:2], 2'b00};
            bwd_d   = al_wdata;
            be_d    = al_be;
          end
        end
      end
      LSU_REQ: begin
        stall  = 1'b1;
        bus_re = ~st_q;
        bus_we = st_q;
        bus_be = be_q;
        if (bus_ready) begin
          rdata_d = st_q ? '0 : al_rdata;
          state_d = LSU_DONE;
        end else if ((TIMEOUT_CYCLES != 0) &&
                     (cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      LSU_DONE: begin
        done       = 1'b1;
        rdata      = rdata_q;
        misaligned = mis_q;
        illegal    = ill_q;
        bus_error  = err_q;
        state_d    = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for the memory stage.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        stall, done, misaligned, illegal, bus_error;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_we, bus_re;

  logic        n_stall, n_done, n_mis, n_ill, n_err;
  logic [31:0] n_rdata, n_baddr, n_bwd;
  logic [3:0]  n_be;
  logic        n_bwe, n_bre;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        ill;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata),
    .misaligned(misaligned), .illegal(illegal),
    .bus_error(bus_error), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_we(bus_we), .bus_re(bus_re),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(0)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(n_stall), .done(n_done), .rdata(n_rdata),
    .misaligned(n_mis), .illegal(n_ill),
    .bus_error(n_err), .bus_addr(n_baddr),
    .bus_wdata(n_bwd), .bus_be(n_be),
    .bus_we(n_bwe), .bus_re(n_bre),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tg, input string nm,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s.%s: observed %h expected %h",
             tg, nm, obs, exp);
    end
  endtask

  task automatic access(
    input string       tg,
    input logic        r,
    input logic        w,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input int          wn,
    input logic [31:0] brd,
    input logic [31:0] er,
    input logic        em,
    input logic        ei,
    input logic        ee,
    input int          lat,
    input logic [3:0]  ebe,
    input logic [31:0] ewd,
    input logic        hold
  );
    exp_t        e, x;
    int          rq;
    logic        fin;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    e.rd = er; e.mis = em; e.ill = ei; e.err = ee; e.lat = lat;
    sbq.push_back(e);
    @(negedge clk);
    re = r; we = w; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'b0;
    #1 chk(tg, "stall_req", 32'(stall), 32'd1);
    rq = 0; fin = 1'b0;
    a0 = '0; w0 = '0; b0 = '0;
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      @(negedge clk);
      if (!hold) begin re = 1'b0; we = 1'b0; end
      bus_ready = 1'b0;
      bus_rdata = 32'hDEADBEEF;
      #1;
      if (done) begin
        x = sbq.pop_front();
        chk(tg, "lat", 32'(cyc), 32'(x.lat));
        chk(tg, "reqcyc", 32'(rq), 32'(x.lat - 1));
        chk(tg, "rdata", rdata, x.rd);
        chk(tg, "mis", 32'(misaligned), 32'(x.mis));
        chk(tg, "ill", 32'(illegal), 32'(x.ill));
        chk(tg, "err", 32'(bus_error), 32'(x.err));
        chk(tg, "stall_done", 32'(stall), 32'd0);
        chk(tg, "be_done", 32'(bus_be), 32'd0);
        fin = 1'b1;
      end else begin
        chk(tg, "stall_wait", 32'(stall), 32'd1);
        if (bus_re || bus_we) begin
          rq++;
          if (rq == 1) begin
            chk(tg, "baddr", bus_addr, {a[31:2], 2'b00});
            chk(tg, "be", 32'(bus_be), 32'(ebe));
            chk(tg, "bre", 32'(bus_re), 32'(r));
            chk(tg, "bwe", 32'(bus_we), 32'(w));
            if (w) chk(tg, "bwdata", bus_wdata, ewd);
            a0 = bus_addr; w0 = bus_wdata; b0 = bus_be;
          end else begin
            chk(tg, "addr_stable", bus_addr, a0);
            chk(tg, "wd_stable", bus_wdata, w0);
            chk(tg, "be_stable", 32'(bus_be), 32'(b0));
          end
          if (wn >= 0 && rq > wn) begin
            bus_ready = 1'b1;
            bus_rdata = brd;
          end
        end
      end
    end
    if (!fin) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s.no_done: observed none expected done", tg);
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst", "stall", 32'(stall), 32'd0);
    chk("rst", "done", 32'(done), 32'd0);
    chk("rst", "rdata", rdata, 32'd0);
    chk("rst", "baddr", bus_addr, 32'd0);
    chk("rst", "bwdata", bus_wdata, 32'd0);
    chk("rst", "bus", 32'({bus_re, bus_we, bus_be}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SB lane replication
    access("sb", 0, 1, 3'd0, 32'h1003, 32'hAB, 0, 0,
           0, 0, 0, 0, 2, 4'b1000, 32'hABABABAB, 0);
    access("sh_lo", 0, 1, 3'd1, 32'h4000, 32'hBEEF, 0, 0,
           0, 0, 0, 0, 2, 4'b0011, 32'hBEEFBEEF, 0);
    access("sh_hi", 0, 1, 3'd1, 32'h4002, 32'h1234BEEF, 0, 0,
           0, 0, 0, 0, 2, 4'b1100, 32'hBEEFBEEF, 0);

    // Load extraction
    access("lb", 1, 0, 3'd0, 32'h2001, 0, 0, 32'h0000F000,
           32'hFFFFFFF0, 0, 0, 0, 2, 4'b0010, 0, 0);
    access("lbu", 1, 0, 3'd4, 32'h2001, 0, 0, 32'h0000F000,
           32'h000000F0, 0, 0, 0, 2, 4'b0010, 0, 0);
    access("lhu", 1, 0, 3'd5, 32'h2002, 0, 0, 32'h80010000,
           32'h00008001, 0, 0, 0, 2, 4'b1100, 0, 0);
    access("lh", 1, 0, 3'd1, 32'h2002, 0, 1, 32'h80010000,
           32'hFFFF8001, 0, 0, 0, 3, 4'b1100, 0, 0);
    access("lw", 1, 0, 3'd2, 32'h2004, 0, 0, 32'h89ABCDEF,
           32'h89ABCDEF, 0, 0, 0, 2, 4'b1111, 0, 0);

    // Faults: no bus activity, done next cycle
    access("lw_mis", 1, 0, 3'd2, 32'h3002, 0, 0, 0,
           0, 1, 0, 0, 1, 4'b0000, 0, 0);
    access("lh_mis", 1, 0, 3'd1, 32'h3001, 0, 0, 0,
           0, 1, 0, 0, 1, 4'b0000, 0, 0);
    access("f3_3", 1, 0, 3'd3, 32'h3000, 0, 0, 0,
           0, 0, 1, 0, 1, 4'b0000, 0, 0);
    access("st_bu", 0, 1, 3'd4, 32'h3000, 0, 0, 0,
           0, 0, 1, 0, 1, 4'b0000, 0, 0);
    access("st_prio", 0, 1, 3'd5, 32'h3001, 0, 0, 0,
           0, 0, 1, 0, 1, 4'b0000, 0, 0);
    access("re_we", 1, 1, 3'd2, 32'h3000, 0, 0, 0,
           0, 0, 1, 0, 1, 4'b0000, 0, 0);

    // Timeout on the 4-cycle instance
    access("tmo", 1, 0, 3'd2, 32'h5000, 0, -1, 0,
           0, 0, 0, 1, 5, 4'b1111, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("notmo", "stall", 32'(n_stall), 32'd1);
      chk("notmo", "done", 32'(n_done), 32'd0);
    end
    @(negedge clk);
    bus_ready = 1'b1;
    bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_ready = 1'b0;
    bus_rdata = 32'hDEADBEEF;
    #1;
    chk("notmo", "done_end", 32'(n_done), 32'd1);
    chk("notmo", "rdata", n_rdata, 32'h12345678);
    chk("notmo", "err", 32'(n_err), 32'd0);
    chk("tmo", "idle_done", 32'(done), 32'd0);

    // Delayed slave with stability checks
    access("sw_dly", 0, 1, 3'd2, 32'h6004, 32'hA5A55A5A, 3, 0,
           0, 0, 0, 0, 5, 4'b1111, 32'hA5A55A5A, 0);

    // Reset in the second REQ cycle
    @(negedge clk);
    we = 1'b1; funct3 = 3'd2;
    addr = 32'h6000; wdata = 32'hCAFEF00D;
    @(negedge clk);
    we = 1'b0;
    #1 chk("rstreq", "bwe1", 32'(bus_we), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rstreq", "bwe2", 32'(bus_we), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstreq", "bwe_rst", 32'(bus_we), 32'd0);
    chk("rstreq", "done", 32'(done), 32'd0);
    chk("rstreq", "stall", 32'(stall), 32'd0);
    chk("rstreq", "baddr", bus_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rstreq", "no_done", 32'(done | n_done), 32'd0);
      chk("rstreq", "idle", 32'(stall | bus_we), 32'd0);
    end

    // Back-to-back with strobes held through DONE
    access("b2b_lw", 1, 0, 3'd2, 32'h7004, 0, 0, 32'h11223344,
           32'h11223344, 0, 0, 0, 2, 4'b1111, 0, 1);
    access("b2b_sw", 0, 1, 3'd2, 32'h7008, 32'h55667788, 0, 0,
           0, 0, 0, 0, 2, 4'b1111, 32'h55667788, 1);
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    #1;
    chk("b2b", "bus_idle", 32'({bus_re, bus_we}), 32'd0);
    chk("b2b", "stall", 32'(stall), 32'd0);
    chk("b2b", "done", 32'(done), 32'd0);
    chk("b2b", "baddr_hold", bus_addr, 32'h7008);
    chk("b2b", "sbq_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the core. Sits directly downstream of the decode/control stage and consumes its `dbus_re`/`dbus_we` strobes, the ALU-computed address and the `rs2` store data.
- Runs a request/ready handshake on the data bus and handles byte lanes, byte enables and sign/zero extension.
- Returns load data for the `DEST_REG_FROM_MEM` writeback path.
- Stalls the core while a transfer is outstanding.

Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum REQ cycles without `bus_ready` before the access is aborted with `bus_error`. 0 disables the timeout.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  synchronous active-low reset
- `re`  in  1  load request (`dbus_re` from control)
- `we`  in  1  store request (`dbus_we` from control)
- `funct3`  in  3  access size/sign: 0=B, 1=H, 2=W, 4=BU, 5=HU
- `addr`  in  32  byte address from ALU
- `wdata`  in  32  store data (`rs2`)
- `stall`  out  1  freeze PC/pipeline
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  32  extended load result, valid while `done`
- `misaligned`  out  1  fault flag, valid while `done`
- `illegal`  out  1  bad `funct3` or `re`&`we`, valid while `done`
- `bus_error`  out  1  timeout flag, valid while `done`
- `bus_addr`  out  32  word-aligned address
- `bus_wdata`  out  32  lane-replicated store data
- `bus_be`  out  4  byte enables
- `bus_we`  out  1  write strobe
- `bus_re`  out  1  read strobe
- `bus_ready`  in  1  slave accepted/completed this cycle
- `bus_rdata`  in  32  read data, valid with `bus_ready`

Behaviour:

Reset:
- On a clock edge with `rst_n`=0: state=IDLE; all outputs 0; timeout counter 0.
- Reset during REQ drops `bus_re`/`bus_we` on that same edge. No `done` is emitted.

States:
- IDLE
  - `re|we` sampled: capture `addr`, `wdata`, `funct3`, direction.
  - Valid access → REQ.
  - Misaligned or illegal access → DONE with the flag set and no bus activity.
  - `stall` = `re|we` (combinational).
- REQ
  - `bus_re`/`bus_we` held, along with stable addr/be/wdata.
  - `bus_ready`=1 → latch the extended load data, go to DONE.
  - Otherwise increment the counter. When counter==`TIMEOUT_CYCLES`-1 and `bus_ready`=0 (with `TIMEOUT_CYCLES`≠0) → DONE with `bus_error`=1 and `rdata`=0.
  - `stall`=1.
- DONE
  - `done`=1, `stall`=0, flags and `rdata` valid for exactly this cycle.
  - Unconditionally → IDLE. `re`/`we` present in this cycle is ignored; the next instruction's request is first seen in IDLE.

Latency:
- Zero-wait-state slave: request in cycle N, `bus_ready` in N+1, `done` in N+2.

Legality rules:
- Misaligned: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0.
- Illegal: `funct3` ∈ {3,6,7}; stores with `funct3`≥3; `re`&`we` both asserted.
- Illegal takes priority over misaligned.

Store lanes (`bus_addr` = `{addr[31:2],2'b00}`):
- SB: `bus_wdata` = `{4{wdata[7:0]}}`, `bus_be` = `1<<addr[1:0]`.
- SH: `bus_wdata` = `{2{wdata[15:0]}}`, `bus_be` = 4'b0011 if `addr[1]`=0, else 4'b1100.
- SW: `bus_wdata` = `wdata`, `bus_be` = 4'b1111.
- Loads drive `bus_be` with the same pattern.

Load extraction:
- Select the lane by `addr[1:0]`.
- B/H: sign-extend from bit 7/15.
- BU/HU: zero-extend.
- W: pass through.

Bus signals outside REQ:
- `bus_re`/`bus_we`/`bus_be` = 0.
- `bus_addr`/`bus_wdata` hold their last value.

Decomposition:
- Types package additions:
  - `mem_size_t` enum (`MEM_B`=3'd0, `MEM_H`=1, `MEM_W`=2, `MEM_BU`=4, `MEM_HU`=5).
  - `lsu_state_t` enum {`LSU_IDLE`, `LSU_REQ`, `LSU_DONE`}.
- One combinational sub-module, `lsu_lane_align`: store replication and byte enables plus load lane select and extension. It is instantiated once; the FSM, counter and registers stay in the top.

Test Plan:
1. SB, `addr`=0x1003, `wdata`=0x000000AB, zero-wait slave → REQ has `bus_addr`=0x1000, `be`=4'b1000, `bus_wdata`=0xABABABAB; `done` 2 cycles after request; `stall` high for 2 cycles.
2. LB at 0x2001 with `bus_rdata`=0x0000F000 → `rdata`=0xFFFFFFF0; LBU same → 0x000000F0; LHU at 0x2002 with 0x8001_0000 → 0x00008001.
3. LW at 0x3002 → `done`+`misaligned` on the next cycle; `bus_re` never asserted. `funct3`=3 → `illegal`=1, no bus activity.
4. LW with slave silent and `TIMEOUT_CYCLES`=4 → 4 REQ cycles, then `done`+`bus_error`, `rdata`=0. With `TIMEOUT_CYCLES`=0, the wait is indefinite until `bus_ready`.
5. SW with `bus_ready` delayed 3 cycles → `be`/`addr`/`wdata` stable throughout REQ; `rst_n`=0 in the 2nd REQ cycle → `bus_we`=0 at that edge, no `done`, IDLE afterwards.
6. Back-to-back LW then SW, `re`/`we` held through DONE → each access issued exactly once; the second request begins in the IDLE cycle after DONE.
